// File: rtl/wave_step_sched.sv
// wave_step_sched: turns a 4-digit BCD frequency setting into a waveform period
// (base / freq, by sequential restoring division) and steps the waveform memory
// address with a fractional accumulator so that exactly 256 memclk strobes
// occur per period.
module wave_step_sched #(
    parameter int DIV_W  = 29,
    parameter int FRQ_W  = 14,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        digit3,
    input  logic [3:0]        digit2,
    input  logic [3:0]        digit1,
    input  logic [3:0]        digit0,
    input  logic [1:0]        range_sel,
    input  logic              cfg_valid,
    input  logic              run,
    output logic              busy,
    output logic [DIV_W-1:0]  period_q,
    output logic [ADDR_W-1:0] addr,
    output logic              memclk,
    output logic              cfg_err,
    output logic              sat
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        CHECK = 3'd2,
        DIV   = 3'd3,
        LOAD  = 3'd4,
        RUN   = 3'd5
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [4:0]         cnt;
    logic [3:0]         digit_cur;
    logic               digit_bad;
    logic [FRQ_W-1:0]   freq;
    logic [DIV_W-1:0]   quo;
    logic [FRQ_W-1:0]   rem;
    logic [FRQ_W:0]     div_res;
    logic [DIV_W:0]     acc_sum;
    logic [DIV_W-1:0]   acc;

    // Dividend for each range selection.
    function automatic logic [DIV_W-1:0] base_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return DIV_W'(50_000_000);
            2'b01:   return DIV_W'(500_000_000);
            2'b10:   return DIV_W'(5_000_000);
            default: return DIV_W'(500_000);
        endcase
    endfunction

    // One BCD-to-binary step: f*10 + d (the result never exceeds 9999).
    function automatic logic [FRQ_W-1:0] conv_step(input logic [FRQ_W-1:0] f,
                                                   input logic [3:0] d);
        return FRQ_W'(({4'b0, f} * (FRQ_W + 4)'(10)) + (FRQ_W + 4)'(d));
    endfunction

    // One restoring-division step; returns {quotient bit, new remainder}.
    // The partial remainder stays below the divisor, so FRQ_W bits hold it
    // and the shifted value needs one extra bit.
    function automatic logic [FRQ_W:0] div_step(input logic [FRQ_W-1:0] r,
                                                input logic b,
                                                input logic [FRQ_W-1:0] d);
        logic [FRQ_W:0] sh;
        sh = {r, b};
        if (sh >= {1'b0, d})
            return {1'b1, FRQ_W'(sh - {1'b0, d})};
        else
            return {1'b0, sh[FRQ_W-1:0]};
    endfunction

    // Digit being converted this cycle, most significant first.
    always_comb begin
        digit_cur = digit3;
        case (cnt[1:0])
            2'd0:    digit_cur = digit3;
            2'd1:    digit_cur = digit2;
            2'd2:    digit_cur = digit1;
            default: digit_cur = digit0;
        endcase
        digit_bad = (digit_cur > 4'd9);
    end

    // Arithmetic shared by the divider and the step accumulator.
    always_comb begin
        div_res = div_step(rem, quo[DIV_W-1], freq);
        acc_sum = {1'b0, acc} + (DIV_W + 1)'(256);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; a new configuration restarts conversion from any state.
    always_comb begin
        next_state = state;
        if (cfg_valid) begin
            next_state = CONV;
        end else begin
            case (state)
                CONV:    if (digit_bad)                 next_state = IDLE;
                         else if (cnt == 5'd3)          next_state = CHECK;
                CHECK:   next_state = (freq == '0) ? IDLE : DIV;
                DIV:     if (cnt == 5'(DIV_W - 1))      next_state = LOAD;
                LOAD:    next_state = RUN;
                default: next_state = state;
            endcase
        end
    end

    // Busy covers everything between accepting a setting and entering RUN.
    always_comb begin
        busy = (state == CONV) || (state == CHECK) || (state == DIV) || (state == LOAD);
    end

    // Control registers, published results and the step accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            period_q <= '0;
            addr     <= '0;
            memclk   <= 1'b0;
            cfg_err  <= 1'b0;
            sat      <= 1'b0;
            acc      <= '0;
        end else begin
            memclk <= 1'b0;
            if (cfg_valid) begin
                cnt     <= '0;
                cfg_err <= 1'b0;
                sat     <= 1'b0;
            end else begin
                case (state)
                    CONV: begin
                        cnt <= cnt + 5'd1;
                        if (digit_bad)
                            cfg_err <= 1'b1;
                    end
                    CHECK: begin
                        cnt <= '0;
                        if (freq == '0) begin
                            period_q <= '0;
                            addr     <= '0;
                            sat      <= 1'b0;
                        end
                    end
                    DIV: begin
                        cnt <= cnt + 5'd1;
                    end
                    LOAD: begin
                        period_q <= quo;
                        sat      <= (quo <= DIV_W'(256));
                        addr     <= '0;
                        acc      <= '0;
                    end
                    RUN: begin
                        if (run) begin
                            if (sat) begin
                                // Period too short: strobe every cycle.
                                memclk <= 1'b1;
                                addr   <= addr + 1'b1;
                                acc    <= '0;
                            end else if (acc_sum >= {1'b0, period_q}) begin
                                memclk <= 1'b1;
                                addr   <= addr + 1'b1;
                                acc    <= DIV_W'(acc_sum - {1'b0, period_q});
                            end else begin
                                acc    <= acc_sum[DIV_W-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Conversion and division datapath; contents only matter once loaded.
    always_ff @(posedge clk) begin
        if (cfg_valid) begin
            freq <= '0;
        end else begin
            case (state)
                CONV: freq <= conv_step(freq, digit_cur);
                CHECK: begin
                    quo <= base_of(range_sel);
                    rem <= '0;
                end
                DIV: begin
                    quo <= {quo[DIV_W-2:0], div_res[FRQ_W]};
                    rem <= div_res[FRQ_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_step_sched.sv
// Directed bench for wave_step_sched: table of settings with hand-computed
// quotients, plus sequences for timing, saturation, restart, freeze and reset.
module tb_wave_step_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  digit3, digit2, digit1, digit0;
    logic [1:0]  range_sel;
    logic        cfg_valid;
    logic        run;
    logic        busy;
    logic [28:0] period_q;
    logic [7:0]  addr;
    logic        memclk;
    logic        cfg_err;
    logic        sat;

    int n_chk  = 0;
    int n_fail = 0;

    wave_step_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit3    (digit3),
        .digit2    (digit2),
        .digit1    (digit1),
        .digit0    (digit0),
        .range_sel (range_sel),
        .cfg_valid (cfg_valid),
        .run       (run),
        .busy      (busy),
        .period_q  (period_q),
        .addr      (addr),
        .memclk    (memclk),
        .cfg_err   (cfg_err),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  d3, d2, d1, d0;
        logic [1:0]  rng;
        logic [28:0] q;
        logic        err;
        logic        sat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d,
                              input logic [1:0] r);
        digit3 = a; digit2 = b; digit1 = c; digit0 = d; range_sel = r;
    endtask

    // Pulse cfg_valid across one rising edge (edge 0); returns just after it.
    task automatic pulse_cfg();
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int     nb;
        int     bad;
        int     first_n;
        int     last_n;
        int     strobes;
        longint k, kp;
        logic   exp_m;
        logic [7:0] exp_a;
        logic [7:0] held;

        rst_n = 1'b0; cfg_valid = 1'b0; run = 1'b0;
        set_digits(0, 0, 0, 0, 2'b00);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_period_q", period_q, 0);
        chk("rst_addr", addr, 0);
        chk("rst_memclk", memclk, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_sat", sat, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Table of settings, run held low so the address stays at 0
        vecs[0]  = '{4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 29'd50000,     1'b0, 1'b0};
        vecs[1]  = '{4'd0, 4'd0, 4'd0, 4'd3, 2'b01, 29'd166666666, 1'b0, 1'b0};
        vecs[2]  = '{4'd9, 4'd9, 4'd9, 4'd9, 2'b11, 29'd50,        1'b0, 1'b1};
        vecs[3]  = '{4'd0, 4'd0, 4'd0, 4'd7, 2'b10, 29'd714285,    1'b0, 1'b0};
        vecs[4]  = '{4'd0, 4'd0, 4'd0, 4'd1, 2'b00, 29'd50000000,  1'b0, 1'b0};
        vecs[5]  = '{4'd9, 4'd9, 4'd9, 4'd9, 2'b01, 29'd50005,     1'b0, 1'b0};
        vecs[6]  = '{4'd1, 4'd9, 4'd5, 4'd3, 2'b11, 29'd256,       1'b0, 1'b1};
        vecs[7]  = '{4'd1, 4'd9, 4'd4, 4'd5, 2'b11, 29'd257,       1'b0, 1'b0};
        vecs[8]  = '{4'd0, 4'hA, 4'd0, 4'd0, 2'b00, 29'd257,       1'b1, 1'b0};
        vecs[9]  = '{4'd9, 4'd9, 4'd9, 4'd9, 2'b00, 29'd5000,      1'b0, 1'b0};
        vecs[10] = '{4'd0, 4'd0, 4'd0, 4'd0, 2'b10, 29'd0,         1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            set_digits(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0, vecs[i].rng);
            pulse_cfg();
            repeat (40) @(negedge clk);
            chk($sformatf("vec%0d_period_q", i), period_q, vecs[i].q);
            chk($sformatf("vec%0d_cfg_err", i), cfg_err, vecs[i].err);
            chk($sformatf("vec%0d_sat", i), sat, vecs[i].sat);
            chk($sformatf("vec%0d_busy", i), busy, 0);
            chk($sformatf("vec%0d_addr", i), addr, 0);
            chk($sformatf("vec%0d_memclk", i), memclk, 0);
        end

        // Zero frequency: busy for exactly 5 cycles, then idle
        set_digits(0, 0, 0, 0, 2'b00);
        pulse_cfg();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("zero_busy_%0d", i), busy, (i < 5) ? 1 : 0);
            @(negedge clk);
        end

        // Full period at Q = 50,000 with run held high
        set_digits(1, 0, 0, 0, 2'b00);
        run = 1'b1;
        pulse_cfg();
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        chk("t1_busy_cycles", nb, 35);
        chk("t1_period_q", period_q, 50000);
        chk("t1_sat", sat, 0);
        bad = 0; first_n = 0; last_n = 0; strobes = 0;
        for (int n = 1; n <= 50000; n++) begin
            @(negedge clk);
            k  = (longint'(n) * 256) / 50000;
            kp = (longint'(n - 1) * 256) / 50000;
            exp_m = (k != kp);
            exp_a = 8'(k % 256);
            if (memclk !== exp_m || addr !== exp_a) begin
                if (bad == 0)
                    $display("FAIL t1_model at cycle %0d: got memclk %0d addr %0d, expected memclk %0d addr %0d",
                             n, memclk, addr, exp_m, exp_a);
                bad++;
            end
            if (memclk === 1'b1) begin
                strobes++;
                if (first_n == 0) first_n = n;
                else if ((n - last_n) != 195 && (n - last_n) != 196) bad++;
                last_n = n;
            end
            if (n == 49999) chk("t1_addr_before_wrap", addr, 255);
            if (n == 50000) chk("t1_addr_wrap", addr, 0);
        end
        chk("t1_model_mismatches", bad, 0);
        chk("t1_first_strobe", first_n, 196);
        chk("t1_strobe_count", strobes, 256);

        // Saturated case: memclk stays high, address advances every cycle
        run = 1'b0;
        set_digits(9, 9, 9, 9, 2'b11);
        pulse_cfg();
        repeat (40) @(negedge clk);
        chk("sat_flag", sat, 1);
        chk("sat_period_q", period_q, 50);
        run = 1'b1;
        bad = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (memclk !== 1'b1 || addr !== 8'(n)) bad++;
        end
        chk("sat_every_cycle", bad, 0);

        // Asynchronous reset in the middle of a division
        run = 1'b0;
        held = addr;
        set_digits(1, 0, 0, 0, 2'b00);
        pulse_cfg();
        repeat (12) @(negedge clk);
        chk("div_busy", busy, 1);
        chk("div_period_q_held", period_q, 50);
        chk("div_addr_held", addr, held);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_period_q", period_q, 0);
        chk("arst_addr", addr, 0);
        chk("arst_memclk", memclk, 0);
        chk("arst_sat", sat, 0);
        chk("arst_cfg_err", cfg_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_period_q", period_q, 0);

        // Restart mid-division with a new setting: latest wins
        set_digits(1, 0, 0, 0, 2'b00);
        pulse_cfg();
        repeat (15) @(negedge clk);
        set_digits(0, 5, 0, 0, 2'b00);
        pulse_cfg();
        repeat (40) @(negedge clk);
        chk("restart_period_q", period_q, 100000);
        chk("restart_busy", busy, 0);

        // Run, freeze for 100 cycles, run again (Q = 100,000)
        run = 1'b1;
        repeat (500) @(negedge clk);
        chk("frz_addr_500", addr, 1);
        run = 1'b0;
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (addr !== 8'd1 || memclk !== 1'b0) bad++;
        end
        chk("frz_hold", bad, 0);
        run = 1'b1;
        repeat (300) @(negedge clk);
        chk("frz_addr_800", addr, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
